cpu_run_monitor: RTL and testbench
==================================

Name: cpu_run_monitor

Overview:
Synthesisable run-control and state-dump monitor for the single-cycle MIPS core (sccomp).
- Watches every retired PC against NUM_BP programmable breakpoints and a retired-instruction budget.
- On a stop condition it asserts halt to freeze the core.
- It then streams the captured PC, the instruction and the register file out over a valid/ready dump port, reading registers through the core's reg_sel/reg_data debug path.

Parameters:
AW, 32, PC width in bits
DW, 32, data width of instructions and registers
NUM_BP, 4, number of breakpoint comparators (1..16)
NREG, 32, registers dumped (r0..r(NREG-1)), 1..32
MAX_CYCLES, 1000, retired-instruction budget; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
pc  in  AW  PC of the instruction retiring this cycle
instr  in  DW  instruction retiring this cycle
pc_valid  in  1  retire strobe; pc and instr are valid
bp_wr  in  1  breakpoint table write strobe
bp_idx  in  clog2(NUM_BP) (min 1)  breakpoint entry to write
bp_addr  in  AW  breakpoint address
bp_en  in  1  entry enable written with bp_addr
restart  in  1  one-cycle pulse; leaves DONE and resumes running
halt  out  1  freezes the core (gate PC update / register writes)
reg_sel  out  5  register index presented to the core's debug read port
reg_data  in  DW  combinational register read data for reg_sel
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts dump word
dump_data  out  DW  dump word
dump_tag  out  6  word index within the dump (0 = PC, 1 = instr, 2.. = registers)
halt_reason  out  2  01 breakpoint, 10 timeout, 11 both, 00 none
done  out  1  dump complete

Behaviour:
- Reset (async, rstn=0): state RUN; halt, dump_valid and done are 0; halt_reason 00; reg_sel 0; dump_tag 0; dump_data 0; retire counter 0; all breakpoint enables cleared.
- Breakpoint table:
  - A write on bp_wr takes effect at the next clock edge.
  - The write is accepted in any state.
  - A write in the same cycle as a compare on the same entry uses the old contents.
- States: RUN, HDR_PC, HDR_INSTR, DUMP, DONE.
- RUN:
  - Each pc_valid increments the retire counter (width clog2(MAX_CYCLES+1), saturating).
  - bp_hit = pc_valid AND any enabled entry equals pc.
  - to_hit = pc_valid AND MAX_CYCLES≠0 AND counter+1 == MAX_CYCLES.
  - On bp_hit or to_hit: capture pc and instr, set halt_reason to {to_hit, bp_hit}, assert halt from the next cycle, and go to HDR_PC.
  - The triggering instruction counts as retired.
- HDR_PC: dump_valid=1, dump_tag=0, dump_data = captured PC zero-extended to DW. Advances on dump_valid & dump_ready.
- HDR_INSTR: dump_tag=1, dump_data = captured instr. Advances on the handshake and loads reg index 0.
- DUMP:
  - reg_sel = index; dump_data = reg_data, except index 0 is forced to 0; dump_tag = index+2.
  - Each handshake increments the index.
  - After the handshake of index NREG-1, go to DONE (or STAMP, see Optional Feature).
- Handshake rule: while dump_valid=1 and dump_ready=0, dump_data and dump_tag hold stable. One word transfers per cycle maximum; back-to-back transfers run at full rate.
- DONE:
  - done=1, halt=1, dump_valid=0.
  - restart moves to RUN, clears halt, done, halt_reason and the counter. Breakpoints are kept.
  - restart in any other state is ignored.
- A breakpoint on the restart PC does not re-trigger until a later retire; the first retire after restart is compared normally.
- pc_valid while halt=1 is ignored.
- rstn assertion mid-dump aborts immediately to the reset state; no partial-dump recovery.

Optional Feature:
MON_CYCLE_STAMP_EN
- Defined: adds state STAMP after DUMP, emitting one extra word (dump_tag = NREG+2) holding the free-running clock-cycle count since the last reset/restart, zero-extended to DW. The counter is 32-bit and wraps. DONE follows STAMP's handshake.
- Undefined: no cycle counter; DUMP goes directly to DONE.

Decomposition:
- Package cpu_mon_pkg: state enum, halt_reason encodings (HR_NONE, HR_BP, HR_TO, HR_BOTH), dump tag constants (TAG_PC=0, TAG_INSTR=1, TAG_REG0=2).
- One sub-module, cpu_mon_bp_table: NUM_BP-entry address/enable register file with a parallel compare producing bp_hit.

Test Plan:
- Breakpoint 0 = 0x00000048 enabled; retire 0x0,0x4,...,0x48 → halt next cycle, halt_reason=01, dump words tag0=0x00000048, tag1=instr, tags 2..33 = register values, r0=0, then done=1.
- MAX_CYCLES=1000, no breakpoints, continuous retires → halt after the 1000th retire, halt_reason=10.
- Enabled breakpoint PC retired exactly as retire 1000 → halt_reason=11.
- dump_ready toggled 1010 pattern during DUMP → each register emitted exactly once in order; dump_data and dump_tag stable while stalled.
- rstn pulled low during DUMP at tag 10 → all outputs at reset values asynchronously; fresh run behaves normally.
- restart in DONE, then retire sequence → counter restarts from 0; breakpoint still active and hits again.

Source files
------------

// File: rtl/cpu_mon_pkg.sv
// rtl/cpu_mon_pkg.sv - shared types and constants for the cpu run monitor
package cpu_mon_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HDR_PC,
    ST_HDR_INSTR,
    ST_DUMP,
    ST_STAMP,
    ST_DONE
  } mon_state_t;

  localparam logic [1:0] HR_NONE = 2'b00;
  localparam logic [1:0] HR_BP   = 2'b01;
  localparam logic [1:0] HR_TO   = 2'b10;
  localparam logic [1:0] HR_BOTH = 2'b11;

  localparam logic [5:0] TAG_PC    = 6'd0;
  localparam logic [5:0] TAG_INSTR = 6'd1;
  localparam logic [5:0] TAG_REG0  = 6'd2;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// rtl/cpu_run_monitor_if.sv - valid/ready dump port carrying tagged state words
interface cpu_run_monitor_if #(
  parameter int DW = 32
);
  logic          dump_valid;
  logic          dump_ready;
  logic [DW-1:0] dump_data;
  logic [5:0]    dump_tag;

  modport master (output dump_valid, output dump_data, output dump_tag, input dump_ready);
  modport slave  (input dump_valid, input dump_data, input dump_tag, output dump_ready);
endinterface

// File: rtl/cpu_mon_bp_table.sv
// rtl/cpu_mon_bp_table.sv - breakpoint address/enable table with parallel compare
module cpu_mon_bp_table #(
  parameter int AW     = 32,
  parameter int NUM_BP = 4,
  parameter int IW     = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr,
  input  logic [IW-1:0] idx,
  input  logic [AW-1:0] addr,
  input  logic          en,
  input  logic [AW-1:0] pc,
  output logic          match
);
  logic [AW-1:0]     bp_addr [NUM_BP];
  logic [NUM_BP-1:0] bp_en;

  // entry write lands at the clock edge, so a same-cycle compare sees the old contents
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bp_en <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr && idx == IW'(i)) begin
          bp_addr[i] <= addr;
          bp_en[i]   <= en;
        end
      end
    end
  end

  // any enabled entry equal to the retiring pc
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && bp_addr[i] == pc) match = 1'b1;
    end
  end
endmodule

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run control and state dump monitor; MON_CYCLE_STAMP_EN adds a cycle stamp word
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NUM_BP     = 4,
  parameter int NREG       = 32,
  parameter int MAX_CYCLES = 1000,
  localparam int BIW       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [AW-1:0]            pc,
  input  logic [DW-1:0]            instr,
  input  logic                     pc_valid,
  input  logic                     bp_wr,
  input  logic [BIW-1:0]           bp_idx,
  input  logic [AW-1:0]            bp_addr,
  input  logic                     bp_en,
  input  logic                     restart,
  output logic                     halt,
  output logic [4:0]               reg_sel,
  input  logic [DW-1:0]            reg_data,
  cpu_run_monitor_if.master        dump,
  output logic [1:0]               halt_reason,
  output logic                     done
);
  localparam int CW   = (MAX_CYCLES > 0) ? $clog2(MAX_CYCLES + 1) : 1;
  localparam int LAST = (MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = LAST[CW-1:0];
  localparam logic [4:0]    IDX_LAST = 5'(NREG - 1);
  localparam int PW = (AW < DW) ? AW : DW;

  mon_state_t    state, state_nxt;
  logic [CW-1:0] ret_cnt;
  logic [AW-1:0] cap_pc;
  logic [DW-1:0] cap_instr;
  logic [DW-1:0] pc_ext;
  logic [4:0]    idx;
  logic [1:0]    reason;
  logic          bp_match, bp_hit, to_hit, trig, xfer, last_reg;

  cpu_mon_bp_table #(.AW(AW), .NUM_BP(NUM_BP), .IW(BIW)) u_bp (
    .clk   (clk),
    .rstn  (rstn),
    .wr    (bp_wr),
    .idx   (bp_idx),
    .addr  (bp_addr),
    .en    (bp_en),
    .pc    (pc),
    .match (bp_match)
  );

  assign bp_hit      = pc_valid & bp_match;
  assign to_hit      = pc_valid && (MAX_CYCLES != 0) && (ret_cnt == CNT_LAST);
  assign trig        = (state == ST_RUN) && (bp_hit || to_hit);
  assign xfer        = dump.dump_valid & dump.dump_ready;
  assign last_reg    = (idx == IDX_LAST);
  assign halt_reason = reason;

`ifdef MON_CYCLE_STAMP_EN
  localparam int SW = (DW < 32) ? DW : 32;
  logic [31:0]   cyc_cnt;
  logic [DW-1:0] stamp_ext;

  // free-running cycle count, restarted together with the run
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cyc_cnt <= '0;
    else if (state == ST_DONE && restart) cyc_cnt <= '0;
    else cyc_cnt <= cyc_cnt + 32'd1;
  end

  // zero-extend the cycle count into a dump word
  always_comb begin
    stamp_ext = '0;
    stamp_ext[SW-1:0] = cyc_cnt[SW-1:0];
  end
`endif

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_RUN;
    else state <= state_nxt;
  end

  // next-state: stop on trigger, walk header words and registers, wait for restart
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:       if (trig) state_nxt = ST_HDR_PC;
      ST_HDR_PC:    if (xfer) state_nxt = ST_HDR_INSTR;
      ST_HDR_INSTR: if (xfer) state_nxt = ST_DUMP;
`ifdef MON_CYCLE_STAMP_EN
      ST_DUMP:      if (xfer && last_reg) state_nxt = ST_STAMP;
`else
      ST_DUMP:      if (xfer && last_reg) state_nxt = ST_DONE;
`endif
      ST_STAMP:     if (xfer) state_nxt = ST_DONE;
      ST_DONE:      if (restart) state_nxt = ST_RUN;
      default:      state_nxt = ST_RUN;
    endcase
  end

  // zero-extend the captured pc into a dump word
  always_comb begin
    pc_ext = '0;
    pc_ext[PW-1:0] = cap_pc[PW-1:0];
  end

  // outputs decoded from state; words only change when the state or index advances
  always_comb begin
    halt            = (state != ST_RUN);
    done            = 1'b0;
    reg_sel         = '0;
    dump.dump_valid = 1'b0;
    dump.dump_data  = '0;
    dump.dump_tag   = TAG_PC;
    case (state)
      ST_HDR_PC: begin
        dump.dump_valid = 1'b1;
        dump.dump_data  = pc_ext;
      end
      ST_HDR_INSTR: begin
        dump.dump_valid = 1'b1;
        dump.dump_tag   = TAG_INSTR;
        dump.dump_data  = cap_instr;
      end
      ST_DUMP: begin
        dump.dump_valid = 1'b1;
        reg_sel         = idx;
        dump.dump_tag   = TAG_REG0 + {1'b0, idx};
        dump.dump_data  = (idx == 5'd0) ? '0 : reg_data;
      end
`ifdef MON_CYCLE_STAMP_EN
      ST_STAMP: begin
        dump.dump_valid = 1'b1;
        dump.dump_tag   = 6'(NREG + 2);
        dump.dump_data  = stamp_ext;
      end
`endif
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // retire counter, trigger capture and stop reason; restart clears count and reason
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ret_cnt   <= '0;
      cap_pc    <= '0;
      cap_instr <= '0;
      reason    <= HR_NONE;
    end else begin
      if (state == ST_RUN && pc_valid && ret_cnt != '1) ret_cnt <= ret_cnt + CW'(1);
      if (trig) begin
        cap_pc    <= pc;
        cap_instr <= instr;
        reason    <= {to_hit, bp_hit};
      end
      if (state == ST_DONE && restart) begin
        ret_cnt <= '0;
        reason  <= HR_NONE;
      end
    end
  end

  // register index walked by the dump
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) idx <= '0;
    else if (state == ST_HDR_INSTR && xfer) idx <= '0;
    else if (state == ST_DUMP && xfer && !last_reg) idx <= idx + 5'd1;
  end
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - self-checking bench for cpu_run_monitor
module tb_cpu_run_monitor;
  localparam int MAXC = 1000;
  localparam int NR   = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc = '0, instr = '0;
  logic        pc_valid = 1'b0, bp_wr = 1'b0, bp_en = 1'b0, restart = 1'b0;
  logic [1:0]  bp_idx = '0;
  logic [31:0] bp_addr = '0;
  logic        halt, done;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [1:0]  halt_reason;
  logic [31:0] regs [NR];

  int tot = 0;
  int bad = 0;

  cpu_run_monitor_if #(.DW(32)) dif ();

  always #5 clk = ~clk;

  assign reg_data = regs[reg_sel];

  cpu_run_monitor #(.AW(32), .DW(32), .NUM_BP(4), .NREG(NR), .MAX_CYCLES(MAXC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .pc          (pc),
    .instr       (instr),
    .pc_valid    (pc_valid),
    .bp_wr       (bp_wr),
    .bp_idx      (bp_idx),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .restart     (restart),
    .halt        (halt),
    .reg_sel     (reg_sel),
    .reg_data    (reg_data),
    .dump        (dif),
    .halt_reason (halt_reason),
    .done        (done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // model: a stop turns into a queue of expected dump words; handshakes pop it
  typedef struct packed { logic [5:0] tag; logic [31:0] data; } word_t;
  word_t       q[$];
  logic [31:0] m_bp_addr [4];
  bit          m_bp_en [4];
  int          m_cnt;
  bit          m_halt;
  logic [1:0]  m_reason;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_cnt = 0; m_halt = 0; m_reason = 2'b00;
      for (int i = 0; i < 4; i++) m_bp_en[i] = 0;
    end else begin
      if (!m_halt) begin
        if (pc_valid) begin
          bit bh, th;
          word_t w;
          m_cnt++;
          bh = 0;
          for (int i = 0; i < 4; i++) if (m_bp_en[i] && m_bp_addr[i] == pc) bh = 1;
          th = (m_cnt == MAXC);
          if (bh || th) begin
            m_halt = 1;
            m_reason = {th, bh};
            w.tag = 6'd0; w.data = pc;    q.push_back(w);
            w.tag = 6'd1; w.data = instr; q.push_back(w);
            for (int r = 0; r < NR; r++) begin
              w.tag = 6'(r + 2);
              w.data = (r == 0) ? 32'd0 : regs[r];
              q.push_back(w);
            end
          end
        end
      end else if (q.size() > 0) begin
        if (dif.dump_ready) void'(q.pop_front());
      end else if (restart) begin
        m_halt = 0; m_reason = 2'b00; m_cnt = 0;
      end
      if (bp_wr) begin
        m_bp_addr[bp_idx] = bp_addr;
        m_bp_en[bp_idx] = bp_en;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("halt", halt, m_halt);
      chk("done", done, m_halt && q.size() == 0);
      chk("reason", halt_reason, m_reason);
      chk("valid", dif.dump_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("tag", dif.dump_tag, q[0].tag);
        chk("data", dif.dump_data, q[0].data);
      end
    end
  end

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return p ^ 32'h8C0A_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bp_write(input logic [1:0] i, input logic [31:0] a, input logic e);
    bp_wr = 1'b1; bp_idx = i; bp_addr = a; bp_en = e;
    tick();
    bp_wr = 1'b0;
  endtask

  task automatic do_restart();
    pc_valid = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic run_from(input logic [31:0] start, output int n);
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      pc = start + 32'(4 * i);
      instr = instr_of(pc);
      pc_valid = 1'b1;
      tick();
      n = i + 1;
      if (halt) break;
    end
    chk("run_halted", halt, 1'b1);
  endtask

  task automatic drain(input bit alt, input int stop_tag, output int hs);
    hs = 0;
    for (int c = 0; c < 200; c++) begin
      if (done) break;
      if (stop_tag >= 0 && dif.dump_valid && dif.dump_tag == 6'(stop_tag)) break;
      dif.dump_ready = alt ? ((c % 2) == 0) : 1'b1;
      #1;
      if (dif.dump_valid && dif.dump_ready) hs++;
      tick();
    end
    dif.dump_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_halt"}, halt, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_valid"}, dif.dump_valid, 1'b0);
    chk({nm, "_reason"}, halt_reason, 2'b00);
    chk({nm, "_regsel"}, reg_sel, 5'd0);
    chk({nm, "_tag"}, dif.dump_tag, 6'd0);
    chk({nm, "_data"}, dif.dump_data, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, hs;
    dif.dump_ready = 1'b0;
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + 32'(i * 32'h0001_0103);
    regs[0] = 32'hDEAD_BEEF;

    #12;
    chk_reset_outputs("reset");
    tick();
    rstn = 1'b1;
    tick();

    // breakpoint at 0x48; restart pulse during the header is ignored
    bp_write(2'd0, 32'h48, 1'b1);
    run_from(32'h0, n);
    chk("t1_n", n, 19);
    chk("t1_reason", halt_reason, 2'b01);
    chk("t1_tag0", dif.dump_tag, 6'd0);
    chk("t1_pcword", dif.dump_data, 32'h48);
    restart = 1'b1; tick(); restart = 1'b0;
    drain(1'b0, -1, hs);
    chk("t1_hs", hs, 34);
    chk("t1_done", done, 1'b1);

    // restart keeps breakpoints, clears counter; dump under 1010 ready
    do_restart();
    chk("t2_cleared", {halt, done, halt_reason}, 4'b0000);
    run_from(32'h0, n);
    chk("t2_n", n, 19);
    chk("t2_reason", halt_reason, 2'b01);
    drain(1'b1, -1, hs);
    chk("t2_hs", hs, 34);

    // timeout only
    bp_write(2'd0, 32'h48, 1'b0);
    do_restart();
    run_from(32'h2000, n);
    chk("t3_n", n, 1000);
    chk("t3_reason", halt_reason, 2'b10);
    drain(1'b0, -1, hs);

    // breakpoint on the 1000th retire
    do_restart();
    bp_write(2'd1, 32'h2F9C, 1'b1);
    run_from(32'h2000, n);
    chk("t4_n", n, 1000);
    chk("t4_reason", halt_reason, 2'b11);
    drain(1'b0, -1, hs);

    // async reset in the middle of the dump
    do_restart();
    bp_write(2'd2, 32'h10, 1'b1);
    run_from(32'h0, n);
    chk("t5_n", n, 5);
    drain(1'b0, 10, hs);
    chk("t5_at_tag10", {dif.dump_valid, dif.dump_tag}, {1'b1, 6'd10});
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    pc_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // fresh run: old entries were cleared by reset
    bp_write(2'd3, 32'h20, 1'b1);
    run_from(32'h0, n);
    chk("t6_n", n, 9);
    chk("t6_reason", halt_reason, 2'b01);
    drain(1'b0, -1, hs);
    chk("t6_hs", hs, 34);
    chk("t6_done", done, 1'b1);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
